// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch front end of the h2bp core.
//
// Owns the program counter and drives the word address into a synchronous
// instruction memory with one-cycle read latency. Delivers (pc, instruction)
// pairs to decode and absorbs decode back-pressure with a one-entry hold
// buffer. A branch redirect squashes everything in flight.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, adds the saturating counters perf_fetched, perf_stall and
//   perf_squash. When undefined, those ports do not exist.
//
// Parameters:
//   RESET_PC         word address fetched first after reset
//   PC_STEP          PC increment per sequential fetch
//
// Ports:
//   clk              core clock
//   rst              synchronous active-high reset
//   fetch_en         permits issuing new fetches
//   imem_pc          fetch address to instruction memory (the req_pc register)
//   imem_instruction memory data for the address presented one cycle earlier
//   redirect_valid   branch/jump taken this cycle
//   redirect_pc      redirect target word address
//   dec_valid        instruction available to decode
//   dec_ready        decode accepts this cycle
//   dec_pc           address of dec_instruction
//   dec_instruction  instruction word
//   perf_fetched     (FETCH_PERF_CNT_EN) accepted instructions
//   perf_stall       (FETCH_PERF_CNT_EN) cycles with dec_valid & !dec_ready
//   perf_squash      (FETCH_PERF_CNT_EN) redirects that discarded live data
//
// Handshake: a transfer to decode happens on a rising edge where dec_valid and
// dec_ready are both high. While dec_valid is high and dec_ready is low, the
// presented dec_pc/dec_instruction stay stable until accepted, unless a
// redirect squashes them.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instruction
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_squash
`endif
);

  // Fetch state
  logic [31:0] r_req_pc;
  logic        r_resp_valid;
  logic [31:0] r_resp_pc;
  logic        r_hold_valid;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_instr;

  logic        w_accept;
  logic        w_issue;
  logic        w_capture;

  // ---------------------------------------------------------------------------
  // Output mux: the hold buffer, when full, is always the older instruction.
  // Outputs are forced quiet during reset so decode never sees stale data.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_pc          = r_resp_pc;
    dec_instruction = imem_instruction;
    if (r_hold_valid) begin
      dec_pc          = r_hold_pc;
      dec_instruction = r_hold_instr;
    end
    dec_valid = (r_hold_valid | r_resp_valid) & ~redirect_valid & ~rst;
  end

  // Memory address follows req_pc, but shows RESET_PC while reset is held so
  // the memory is already reading the first word when reset releases.
  assign imem_pc = rst ? RESET_PC : r_req_pc;

  assign w_accept = dec_valid & dec_ready;

  // A new fetch may only go out if its data will have a place to land next
  // cycle: the hold buffer is empty and the current response leaves now.
  assign w_issue = fetch_en & ~redirect_valid & ~r_hold_valid
                 & (~r_resp_valid | dec_ready);

  // The memory re-reads req_pc at the edge and overwrites its output, so a
  // stalled response must be parked in the hold buffer.
  assign w_capture = r_resp_valid & ~r_hold_valid & ~dec_ready & ~redirect_valid;

  // ---------------------------------------------------------------------------
  // Fetch state update. Redirect outranks accept, capture and issue.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_pc     <= RESET_PC;
      r_resp_valid <= 1'b0;
      r_resp_pc    <= RESET_PC;
      r_hold_valid <= 1'b0;
      r_hold_pc    <= 32'h0;
      r_hold_instr <= 32'h0;
    end else if (redirect_valid) begin
      r_req_pc     <= redirect_pc;
      r_resp_valid <= 1'b0;
      r_hold_valid <= 1'b0;
    end else begin
      r_resp_valid <= w_issue;
      if (w_issue) begin
        r_resp_pc <= r_req_pc;
        r_req_pc  <= r_req_pc + PC_STEP;
      end
      if (w_capture) begin
        r_hold_valid <= 1'b1;
        r_hold_pc    <= r_resp_pc;
        r_hold_instr <= imem_instruction;
      end else if (r_hold_valid && w_accept) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters.
  // ---------------------------------------------------------------------------
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_squash;
  logic        w_stall_evt;
  logic        w_squash_evt;

  assign w_stall_evt  = dec_valid & ~dec_ready;
  assign w_squash_evt = redirect_valid & (r_hold_valid | r_resp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= 32'h0;
      r_perf_stall   <= 32'h0;
      r_perf_squash  <= 32'h0;
    end else begin
      if (w_accept && (r_perf_fetched != 32'hFFFF_FFFF)) begin
        r_perf_fetched <= r_perf_fetched + 32'h1;
      end
      if (w_stall_evt && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'h1;
      end
      if (w_squash_evt && (r_perf_squash != 32'hFFFF_FFFF)) begin
        r_perf_squash <= r_perf_squash + 32'h1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
  assign perf_squash  = r_perf_squash;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- directed bench for fetch_unit.
// Two instances share clock, reset and fetch_en: dut runs the main scenario
// with RESET_PC = 0; dut_wrap has RESET_PC = 0xFFFFFFFF, decode always ready
// and no redirects, to exercise PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;

  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instruction;

  logic [31:0] imem_pc_w;
  logic [31:0] imem_instruction_w;
  logic        dec_valid_w;
  logic [31:0] dec_pc_w;
  logic [31:0] dec_instruction_w;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, perf_squash;
  logic [31:0] perf_fetched_w, perf_stall_w, perf_squash_w;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Instruction memory model (one-cycle read latency)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'd0:   mem_word = 32'h0843_5555;
      32'd4:   mem_word = 32'h08C7_5555;
      32'd8:   mem_word = 32'h8046_000E;
      default: mem_word = 32'h0000_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    imem_instruction   <= mem_word(imem_pc);
    imem_instruction_w <= mem_word(imem_pc_w);
  end

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'h1)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_en         (fetch_en),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .dec_pc           (dec_pc),
    .dec_instruction  (dec_instruction)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_stall       (perf_stall),
    .perf_squash      (perf_squash)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .PC_STEP(32'h1)) dut_wrap (
    .clk              (clk),
    .rst              (rst),
    .fetch_en         (fetch_en),
    .imem_pc          (imem_pc_w),
    .imem_instruction (imem_instruction_w),
    .redirect_valid   (1'b0),
    .redirect_pc      (32'h0),
    .dec_valid        (dec_valid_w),
    .dec_ready        (1'b1),
    .dec_pc           (dec_pc_w),
    .dec_instruction  (dec_instruction_w)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched     (perf_fetched_w),
    .perf_stall       (perf_stall_w),
    .perf_squash      (perf_squash_w)
`endif
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr);
    check_eq({tag, ".valid"}, {31'h0, dec_valid}, 32'h1);
    check_eq({tag, ".pc"}, dec_pc, pc);
    check_eq({tag, ".instr"}, dec_instruction, instr);
  endtask

  task automatic expect_wrap(input string tag, input logic [31:0] pc,
                             input logic [31:0] instr);
    check_eq({tag, ".valid"}, {31'h0, dec_valid_w}, 32'h1);
    check_eq({tag, ".pc"}, dec_pc_w, pc);
    check_eq({tag, ".instr"}, dec_instruction_w, instr);
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, ".valid"}, {31'h0, dec_valid}, 32'h0);
  endtask

  // Advance to just after the next active edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; fetch_en = 1'b0; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick; tick;
    #1;
    expect_idle("rst");
    check_eq("rst.imem_pc", imem_pc, 32'h0);
    check_eq("rst.imem_pc_wrap", imem_pc_w, 32'hFFFF_FFFF);

    // Reset release: first issue this cycle, data one cycle later.
    rst = 1'b0; fetch_en = 1'b1; #1;
    expect_idle("first_issue");
    check_eq("first_issue.imem_pc", imem_pc, 32'h0);
    tick; #1;
    expect_out("pc0", 32'd0, 32'h0843_5555);
    expect_wrap("wrap0", 32'hFFFF_FFFF, 32'h0);
    tick; #1;
    expect_out("pc1", 32'd1, 32'h0);
    expect_wrap("wrap1", 32'h0, 32'h0843_5555);
    tick; #1;
    expect_out("pc2", 32'd2, 32'h0);
    expect_wrap("wrap2", 32'h1, 32'h0);
    tick; #1;
    expect_out("pc3", 32'd3, 32'h0);

    // Stall three cycles on pc 4.
    tick; dec_ready = 1'b0; #1;
    expect_out("stall1", 32'd4, 32'h08C7_5555);
    tick; #1;
    expect_out("stall2", 32'd4, 32'h08C7_5555);
    tick; #1;
    expect_out("stall3", 32'd4, 32'h08C7_5555);
    tick; dec_ready = 1'b1; #1;
    expect_out("release", 32'd4, 32'h08C7_5555);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_stall", perf_stall, 32'd3);
`endif
    tick; #1;
    expect_idle("bubble");
    tick; #1;
    expect_out("pc5", 32'd5, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetched", perf_fetched, 32'd5);
`endif

    // Reset in the middle of a stall with the hold buffer full.
    tick; dec_ready = 1'b0; #1;
    expect_out("pc6", 32'd6, 32'h0);
    tick; rst = 1'b1; #1;
    expect_idle("mid_rst");
    check_eq("mid_rst.imem_pc", imem_pc, 32'h0);
    tick; rst = 1'b0; dec_ready = 1'b1; #1;
    expect_idle("post_rst");
    check_eq("post_rst.imem_pc", imem_pc, 32'h0);
    tick; #1;
    expect_out("restart_pc0", 32'd0, 32'h0843_5555);
    tick; #1;
    expect_out("restart_pc1", 32'd1, 32'h0);

    // Redirect to 8 while pc 2 is on the output.
    tick; redirect_valid = 1'b1; redirect_pc = 32'd8; #1;
    expect_idle("redir_cycle");
    tick; redirect_valid = 1'b0; #1;
    expect_idle("redir_next");
    check_eq("redir_next.imem_pc", imem_pc, 32'd8);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_squash", perf_squash, 32'd1);
`endif
    tick; dec_ready = 1'b0; #1;
    expect_out("target8", 32'd8, 32'h8046_000E);

    // Redirect while stalled with hold full: hold must be discarded.
    tick; redirect_valid = 1'b1; redirect_pc = 32'd0; #1;
    expect_idle("redir_hold");
    tick; redirect_valid = 1'b0; dec_ready = 1'b1; #1;
    expect_idle("redir_hold_next");
    tick; fetch_en = 1'b0; #1;
    expect_out("target0", 32'd0, 32'h0843_5555);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_squash2", perf_squash, 32'd2);
`endif

    // fetch_en low: outstanding pc 0 delivered above, req_pc frozen at 1.
    tick; #1;
    expect_idle("fe_off1");
    check_eq("fe_off1.imem_pc", imem_pc, 32'd1);
    tick; #1;
    expect_idle("fe_off2");
    check_eq("fe_off2.imem_pc", imem_pc, 32'd1);
    fetch_en = 1'b1;
    tick; #1;
    expect_out("fe_on_pc1", 32'd1, 32'h0);
    tick; #1;
    expect_out("fe_on_pc2", 32'd2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
